div_ctrl: RTL and testbench

Iterative 32-bit divide controller for the HI/LO path. It accepts a DIV/DIVU from the EX stage and holds the pipeline with a stall request while a radix-2 restoring-division FSM runs. On completion it presents the quotient and remainder as a one-cycle HI/LO write, which EX forwards into its hilo write bus and the EX/MEM/WB forwarding buses.

---
 rtl/div_ctrl_pkg.sv | 24 ++
 rtl/div_step.sv | 25 ++
 rtl/div_ctrl.sv | 145 ++++++++++++++
 tb/tb_div_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants and helpers for the iterative HI/LO divide controller.
package div_ctrl_pkg;

  // Legacy-compatible 2-bit state encodings
  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_BUSY = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

  // Width of the {hi_we, lo_we, hi, lo} bundle carried on the EX forwarding bus
  localparam int unsigned DIV_TO_EX_WD = 66;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } div_to_ex_t;

  // Two's-complement negate when neg is set
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] dvd,
  input  logic [31:0] dsr,
  output logic [31:0] rem_next,
  output logic [31:0] dvd_next,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // Shift {rem, dvd} left one, trial-subtract the divisor, restore on borrow.
  // rem < dsr holds on entry, so a 33-bit difference has an unambiguous sign bit.
  always_comb begin
    shifted  = {rem, dvd[31]};
    diff     = shifted - {1'b0, dsr};
    q_bit    = ~diff[32];
    rem_next = q_bit ? diff[31:0] : shifted[31:0];
    // Dividend bits drain out the top while quotient bits fill in from the bottom
    dvd_next = {dvd[30:0], q_bit};
  end

endmodule

// File: rtl/div_ctrl.sv
// Iterative 32-bit DIV/DIVU controller: stalls EX while a restoring divider runs,
// then presents remainder/quotient as a one-cycle HI/LO write.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        cancel,
  output logic        stallreq,
  output logic        done,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(ITER);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      dvd_q, dvd_d;  // dividend magnitude, becomes the quotient
  logic [31:0]      dsr_q, dsr_d;  // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic [31:0] step_rem;
  logic [31:0] step_dvd;
  logic        step_q_bit;

  div_to_ex_t ex_bus;

  div_step u_div_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .dsr      (dsr_q),
    .rem_next (step_rem),
    .dvd_next (step_dvd),
    .q_bit    (step_q_bit)
  );

  // Next-state: accept in IDLE, iterate in BUSY, single-cycle DONE; cancel wins everywhere
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;

    if (cancel) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            cnt_d = '0;
            if (opdata2 == 32'd0) begin
              // Divide by zero: all-ones quotient, raw dividend as remainder, no fix-up
              state_d = DIV_DONE;
              rem_d   = opdata1;
              dvd_d   = 32'hFFFF_FFFF;
              dsr_d   = opdata2;
              q_neg_d = 1'b0;
              r_neg_d = 1'b0;
            end else begin
              state_d = DIV_BUSY;
              rem_d   = 32'd0;
              dvd_d   = neg_if(opdata1, signed_div & opdata1[31]);
              dsr_d   = neg_if(opdata2, signed_div & opdata2[31]);
              q_neg_d = signed_div & (opdata1[31] ^ opdata2[31]);
              r_neg_d = signed_div & opdata1[31];
            end
          end
        end
        DIV_BUSY: begin
          rem_d = step_rem;
          dvd_d = step_dvd;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: begin
          state_d = DIV_IDLE;
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= 32'd0;
      dvd_q   <= 32'd0;
      dsr_q   <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  // Stall is combinational from start so EX holds in the accept cycle; low in DONE
  always_comb begin
    stallreq = ((state_q == DIV_IDLE) & start & ~cancel) | (state_q == DIV_BUSY);
  end

  // HI/LO write bundle with sign fix-up; zero whenever no result is presented
  always_comb begin
    ex_bus = '0;
    if ((state_q == DIV_DONE) && !cancel) begin
      ex_bus.hi_we = 1'b1;
      ex_bus.lo_we = 1'b1;
      ex_bus.hi    = neg_if(rem_q, r_neg_q);
      ex_bus.lo    = neg_if(dvd_q, q_neg_q);
    end
  end

  assign done  = ex_bus.lo_we;
  assign hi_we = ex_bus.hi_we;
  assign lo_we = ex_bus.lo_we;
  assign hi_o  = ex_bus.hi;
  assign lo_o  = ex_bus.lo;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed scenarios plus randomized operands
// checked against a plain-arithmetic reference model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        cancel = 1'b0;
  logic        stallreq, done, hi_we, lo_we;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_errors = 0;

  div_ctrl #(.ITER(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .cancel     (cancel),
    .stallreq   (stallreq),
    .done       (done),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics, divide-by-zero yields all-ones / raw dividend
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = 32'(lq);
      r  = 32'(lr);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Present an operation on a negedge (cycle T) and expect an immediate stall
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk);
    start      = 1'b1;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    #1;
    check("stall_accept", 32'(stallreq), 32'd1);
  endtask

  // Wait for done, checking stall each cycle, latency and the written result
  task automatic await_done(input string tag, input int exp_lat,
                            input logic [31:0] eq, input logic [31:0] er);
    int lat = 0;
    bit seen = 0;
    while (lat < 80 && !seen) begin
      @(negedge clk);
      lat++;
      #1;
      if (done) seen = 1;
      else check({tag, "_stall"}, 32'(stallreq), 32'd1);
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_lo"}, lo_o, eq);
    check({tag, "_hi"}, hi_o, er);
    check({tag, "_we"}, {30'd0, hi_we, lo_we}, 32'd3);
    check({tag, "_stall_done"}, 32'(stallreq), 32'd0);
  endtask

  // Drop start in the DONE cycle and confirm the write lasted one cycle only
  task automatic retire(input string tag);
    start = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_done_off"}, {29'd0, done, hi_we, lo_we}, 32'd0);
    check({tag, "_out_zero"}, hi_o | lo_o, 32'd0);
    check({tag, "_stall_off"}, 32'(stallreq), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    logic        sgn;
    int          sel;

    // Reset state
    #2;
    check("rst_outs", {28'd0, stallreq, done, hi_we, lo_we}, 32'd0);
    check("rst_data", hi_o | lo_o, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // DIVU 100 / 7
    issue(32'd100, 32'd7, 1'b0);
    await_done("divu_100_7", 33, 32'd14, 32'd2);
    retire("divu_100_7");

    // DIV -7 / 2 and DIVU with the same bit patterns
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    await_done("div_m7_2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    retire("div_m7_2");
    issue(32'hFFFF_FFF9, 32'd2, 1'b0);
    await_done("divu_m7_2", 33, 32'h7FFF_FFFC, 32'd1);
    retire("divu_m7_2");

    // Signed overflow wraps
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    await_done("div_ovf", 33, 32'h8000_0000, 32'd0);
    retire("div_ovf");

    // Divide by zero completes in one cycle, signed and unsigned
    issue(32'd5, 32'd0, 1'b0);
    await_done("divu_5_0", 1, 32'hFFFF_FFFF, 32'd5);
    retire("divu_5_0");
    issue(32'hFFFF_FFF0, 32'd0, 1'b1);
    await_done("div_m16_0", 1, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    retire("div_m16_0");

    // Cancel at T+10, flush drops start; restart at T+12
    issue(32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    start  = 1'b0;
    #1;
    check("cancel_no_done", {30'd0, done, lo_we}, 32'd0);
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("cancel_idle_stall", 32'(stallreq), 32'd0);
    check("cancel_idle_done", 32'(done), 32'd0);
    issue(32'd9, 32'd3, 1'b0);
    await_done("after_cancel", 33, 32'd3, 32'd0);
    retire("after_cancel");

    // Back-to-back with start held high: second op accepted in the cycle after DONE
    issue(32'd50, 32'd6, 1'b0);
    await_done("b2b_first", 33, 32'd8, 32'd2);
    opdata1 = 32'd77;
    opdata2 = 32'd10;
    await_done("b2b_second", 34, 32'd7, 32'd7);
    retire("b2b_second");

    // Reset asserted mid-operation at T+20, with EX also dropping start
    issue(32'd12345, 32'd17, 1'b1);
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    start  = 1'b0;
    #1;
    check("midrst_outs", {28'd0, stallreq, done, hi_we, lo_we}, 32'd0);
    check("midrst_data", hi_o | lo_o, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("midrst_quiet", {30'd0, done, stallreq}, 32'd0);
    end
    issue(32'd20, 32'hFFFF_FFFD, 1'b1);
    await_done("div_20_m3", 33, 32'hFFFF_FFFA, 32'd2);
    retire("div_20_m3");

    // Randomized operands with boundary biasing
    for (int i = 0; i < 16; i++) begin
      a   = $urandom;
      b   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      model(a, b, sgn, q, r);
      issue(a, b, sgn);
      await_done("rand", (b == 32'd0) ? 1 : 33, q, r);
      retire("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
